// File: rtl/branch_merger.sv
// Round-robin merger of per-branch result channels into one registered output
// slot. Optional build macro BRANCH_MERGER_ORDERED_EN restricts eligibility to
// the branch whose commit id matches the next expected id, so results commit
// in order.
`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

module branch_merger #(
  parameter int data_width = 16,
  parameter int full_width = 2*data_width+8,
  parameter int n_branches = `N_INSTR_BRANCHES,
  localparam int CW = `COMMIT_ID_WIDTH,
  localparam int BW = (n_branches > 1) ? $clog2(n_branches) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [n_branches-1:0]               in_valid,
  output logic [n_branches-1:0]               in_ready,
  input  logic [n_branches*data_width-1:0]    in_result,
  input  logic [n_branches*4-1:0]             in_dest,
  input  logic [n_branches*8-1:0]             in_res_addr,
  input  logic [n_branches*CW-1:0]            in_commit_id,
  input  logic [n_branches-1:0]               in_commit_flag,
  input  logic [n_branches-1:0]               in_writes_external,
  input  logic [n_branches*full_width-1:0]    in_accumulator,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [data_width-1:0]               result_out,
  output logic [3:0]                          dest_out,
  output logic [7:0]                          res_addr_out,
  output logic [CW-1:0]                       commit_id_out,
  output logic                                commit_flag_out,
  output logic                                writes_external_out,
  output logic signed [full_width-1:0]        accumulator_out,
  output logic [BW-1:0]                       src_branch_out
);

  logic                         out_valid_q, out_valid_d;
  logic [data_width-1:0]        result_q, result_d;
  logic [3:0]                   dest_q, dest_d;
  logic [7:0]                   res_addr_q, res_addr_d;
  logic [CW-1:0]                commit_id_q, commit_id_d;
  logic                         commit_flag_q, commit_flag_d;
  logic                         wext_q, wext_d;
  logic signed [full_width-1:0] acc_q, acc_d;
  logic [BW-1:0]                src_q, src_d;
  logic [BW-1:0]                last_grant_q, last_grant_d;
`ifdef BRANCH_MERGER_ORDERED_EN
  logic [CW-1:0]                expected_id_q, expected_id_d;
`endif

  logic [n_branches-1:0] eligible;
  logic                  slot_free;
  logic                  grant;
  logic [BW-1:0]         grant_idx;

  // Eligibility per branch; in ordered mode only the expected commit id may go
  always_comb begin
    eligible = '0;
    for (int i = 0; i < n_branches; i++) begin
`ifdef BRANCH_MERGER_ORDERED_EN
      eligible[i] = in_valid[i] && (in_commit_id[i*CW +: CW] == expected_id_q);
`else
      eligible[i] = in_valid[i];
`endif
    end
  end

  // Round-robin search starting just above the last granted branch
  always_comb begin
    int idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= n_branches; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= n_branches) idx = idx - n_branches;
      if (!found && eligible[idx]) begin
        found     = 1'b1;
        grant_idx = BW'(idx);
      end
    end
    slot_free = ~out_valid_q | out_ready;
    grant     = enable & slot_free & found;
    in_ready  = '0;
    if (grant) in_ready[grant_idx] = 1'b1;
  end

  // Next state of the output slot and arbitration/ordering state
  always_comb begin
    out_valid_d   = out_valid_q;
    result_d      = result_q;
    dest_d        = dest_q;
    res_addr_d    = res_addr_q;
    commit_id_d   = commit_id_q;
    commit_flag_d = commit_flag_q;
    wext_d        = wext_q;
    acc_d         = acc_q;
    src_d         = src_q;
    last_grant_d  = last_grant_q;
`ifdef BRANCH_MERGER_ORDERED_EN
    expected_id_d = expected_id_q;
`endif
    if (reset) begin
      out_valid_d   = 1'b0;
      result_d      = '0;
      dest_d        = '0;
      res_addr_d    = '0;
      commit_id_d   = '0;
      commit_flag_d = 1'b0;
      wext_d        = 1'b0;
      acc_d         = '0;
      src_d         = '0;
      last_grant_d  = BW'(n_branches - 1);
`ifdef BRANCH_MERGER_ORDERED_EN
      expected_id_d = '0;
`endif
    end else if (grant) begin
      out_valid_d   = 1'b1;
      result_d      = in_result[int'(grant_idx)*data_width +: data_width];
      dest_d        = in_dest[int'(grant_idx)*4 +: 4];
      res_addr_d    = in_res_addr[int'(grant_idx)*8 +: 8];
      commit_id_d   = in_commit_id[int'(grant_idx)*CW +: CW];
      commit_flag_d = in_commit_flag[grant_idx];
      wext_d        = in_writes_external[grant_idx];
      acc_d         = in_accumulator[int'(grant_idx)*full_width +: full_width];
      src_d         = grant_idx;
      last_grant_d  = grant_idx;
`ifdef BRANCH_MERGER_ORDERED_EN
      if (in_commit_flag[grant_idx]) expected_id_d = expected_id_q + 1'b1;
`endif
    end else if (enable && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers (reset folded into the next-state logic)
  always_ff @(posedge clk) begin
    out_valid_q   <= out_valid_d;
    result_q      <= result_d;
    dest_q        <= dest_d;
    res_addr_q    <= res_addr_d;
    commit_id_q   <= commit_id_d;
    commit_flag_q <= commit_flag_d;
    wext_q        <= wext_d;
    acc_q         <= acc_d;
    src_q         <= src_d;
    last_grant_q  <= last_grant_d;
`ifdef BRANCH_MERGER_ORDERED_EN
    expected_id_q <= expected_id_d;
`endif
  end

  assign out_valid           = out_valid_q;
  assign result_out          = result_q;
  assign dest_out            = dest_q;
  assign res_addr_out        = res_addr_q;
  assign commit_id_out       = commit_id_q;
  assign commit_flag_out     = commit_flag_q;
  assign writes_external_out = wext_q;
  assign accumulator_out     = acc_q;
  assign src_branch_out      = src_q;

endmodule

// File: tb/tb_branch_merger.sv
// Directed testbench for branch_merger (default 4 branches, 16-bit results).
`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

module tb_branch_merger;
  localparam int DW = 16;
  localparam int FW = 2*DW+8;
  localparam int NB = `N_INSTR_BRANCHES;
  localparam int CW = `COMMIT_ID_WIDTH;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  logic clk = 1'b0;
  logic reset, enable, out_ready;
  logic [NB-1:0]    in_valid, in_ready, in_commit_flag, in_writes_external;
  logic [NB*DW-1:0] in_result;
  logic [NB*4-1:0]  in_dest;
  logic [NB*8-1:0]  in_res_addr;
  logic [NB*CW-1:0] in_commit_id;
  logic [NB*FW-1:0] in_accumulator;
  logic             out_valid, commit_flag_out, writes_external_out;
  logic [DW-1:0]    result_out;
  logic [3:0]       dest_out;
  logic [7:0]       res_addr_out;
  logic [CW-1:0]    commit_id_out;
  logic signed [FW-1:0] accumulator_out;
  logic [BW-1:0]    src_branch_out;

  int errors = 0;
  int checks = 0;

  branch_merger #(.data_width(DW), .full_width(FW), .n_branches(NB)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_dest(in_dest), .in_res_addr(in_res_addr), .in_commit_id(in_commit_id),
    .in_commit_flag(in_commit_flag), .in_writes_external(in_writes_external),
    .in_accumulator(in_accumulator), .out_valid(out_valid), .out_ready(out_ready),
    .result_out(result_out), .dest_out(dest_out), .res_addr_out(res_addr_out),
    .commit_id_out(commit_id_out), .commit_flag_out(commit_flag_out),
    .writes_external_out(writes_external_out), .accumulator_out(accumulator_out),
    .src_branch_out(src_branch_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1; out_ready = 1'b1; in_valid = '0;
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
    checks++; if (src_branch_out !== '0) begin errors++; $display("FAIL rst_src got=%0d exp=0", src_branch_out); end
    checks++; if (result_out !== '0) begin errors++; $display("FAIL rst_result got=%h exp=0", result_out); end
    checks++; if (accumulator_out !== '0) begin errors++; $display("FAIL rst_acc got=%h exp=0", accumulator_out); end
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
  endtask

  task automatic test_single();
    in_result[0 +: DW] = 16'h1234;
    in_dest[0 +: 4] = 4'h3;
    in_res_addr[0 +: 8] = 8'hA5;
    in_accumulator[0 +: FW] = -40'sd5;
    in_writes_external[0] = 1'b1;
    in_valid = 4'b0001; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", in_ready); end
    tick();
    in_valid = '0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
    checks++; if (result_out !== 16'h1234) begin errors++; $display("FAIL single_result got=%h exp=1234", result_out); end
    checks++; if (src_branch_out !== 2'd0) begin errors++; $display("FAIL single_src got=%0d exp=0", src_branch_out); end
    checks++; if (dest_out !== 4'h3 || res_addr_out !== 8'hA5) begin errors++; $display("FAIL single_fields got=%h/%h exp=3/a5", dest_out, res_addr_out); end
    checks++; if (accumulator_out !== -40'sd5) begin errors++; $display("FAIL single_acc got=%0d exp=-5", accumulator_out); end
    checks++; if (writes_external_out !== 1'b1) begin errors++; $display("FAIL single_wext got=%0b exp=1", writes_external_out); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NB; i++) in_result[i*DW +: DW] = DW'(16'h0100 + i);
    in_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < NB + 1; k++) begin
      #1;
      checks++; if (in_ready !== NB'(1 << (k % NB))) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, in_ready, NB'(1 << (k % NB))); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || src_branch_out !== BW'(k % NB) || result_out !== DW'(16'h0100 + (k % NB))) begin
        errors++; $display("FAIL rr_out[%0d] got=v%0b s%0d r%h exp=v1 s%0d r%h", k, out_valid, src_branch_out, result_out, k % NB, 16'h0100 + (k % NB));
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_wrap();
    // last grant is 0 here; branches 3 and 0 valid -> 3 first, then 0
    in_valid = 4'b1001; out_ready = 1'b1;
    tick();
    checks++; if (src_branch_out !== 2'd3) begin errors++; $display("FAIL wrap_first got=%0d exp=3", src_branch_out); end
    tick();
    checks++; if (src_branch_out !== 2'd0) begin errors++; $display("FAIL wrap_second got=%0d exp=0", src_branch_out); end
    in_valid = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    in_valid = 4'b0010; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || src_branch_out !== 2'd1) begin errors++; $display("FAIL bp_setup got=v%0b s%0d exp=v1 s1", out_valid, src_branch_out); end
    out_ready = 1'b0; in_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (in_ready !== '0) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || src_branch_out !== 2'd1 || result_out !== 16'h0101) begin errors++; $display("FAIL bp_hold[%0d] got=v%0b s%0d r%h exp=v1 s1 r0101", k, out_valid, src_branch_out, result_out); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release got=%b exp=0100", in_ready); end
    tick();
    in_valid = '0;
    checks++; if (out_valid !== 1'b1 || src_branch_out !== 2'd2 || result_out !== 16'h0102) begin errors++; $display("FAIL bp_next got=v%0b s%0d r%h exp=v1 s2 r0102", out_valid, src_branch_out, result_out); end
    tick();
  endtask

  task automatic test_enable();
    enable = 1'b0; in_valid = 4'b0010; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL en_ready got=%b exp=0000", in_ready); end
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_hold got=%0b exp=0", out_valid); end
    enable = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL en_grant got=%b exp=0010", in_ready); end
    tick();
    in_valid = '0;
    checks++; if (out_valid !== 1'b1 || src_branch_out !== 2'd1) begin errors++; $display("FAIL en_out got=v%0b s%0d exp=v1 s1", out_valid, src_branch_out); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || src_branch_out !== '0 || result_out !== '0) begin errors++; $display("FAIL mid_rst got=v%0b s%0d r%h exp=v0 s0 r0000", out_valid, src_branch_out, result_out); end
    in_valid = '1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_first got=%b exp=0001", in_ready); end
    tick();
    in_valid = '0;
    checks++; if (src_branch_out !== 2'd0) begin errors++; $display("FAIL mid_src got=%0d exp=0", src_branch_out); end
    tick();
  endtask

`ifdef BRANCH_MERGER_ORDERED_EN
  task automatic test_ordered();
    do_reset();
    in_commit_id = '0;
    in_commit_id[0 +: CW] = CW'(1);
    in_commit_id[CW +: CW] = CW'(0);
    in_commit_flag = 4'b0011;
    in_valid = 4'b0011; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL ord_first got=%b exp=0010", in_ready); end
    tick();
    in_valid = 4'b0001;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL ord_second got=%b exp=0001", in_ready); end
    tick();
    in_valid = '0;
    // walk expected_id up to all-ones then check wrap to 0
    for (int k = 2; k < (1 << CW); k++) begin
      in_commit_id[0 +: CW] = CW'(k); in_valid = 4'b0001;
      tick();
    end
    in_commit_id[0 +: CW] = CW'(0); in_valid = 4'b0001;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL ord_wrap got=%b exp=0001", in_ready); end
    tick();
    in_valid = '0;
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1; in_valid = '0;
    in_result = '0; in_dest = '0; in_res_addr = '0; in_commit_id = '0;
    in_commit_flag = '0; in_writes_external = '0; in_accumulator = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_back_to_back();
    test_enable();
    test_reset_mid();
`ifdef BRANCH_MERGER_ORDERED_EN
    test_ordered();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_merger.md
BRANCH_MERGER -- requirements
Module: branch_merger

Interface
REQ-001 Parameter data_width, default 16, width of the result word.
REQ-002 Parameter full_width, default 2*data_width+8, width of the accumulator word.
REQ-003 Parameter n_branches, default `N_INSTR_BRANCHES, number of branch result channels; BW = max(1, $clog2(n_branches)).
REQ-004 clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  global advance qualifier.
REQ-006 in_valid  in  n_branches  per-branch result valid.
REQ-007 in_ready  out  n_branches  per-branch accept; at most one bit high.
REQ-008 in_result  in  n_branches*data_width  packed results, branch i at [i*data_width +: data_width].
REQ-009 in_dest  in  n_branches*4; in_res_addr  in  n_branches*8; in_commit_id  in  n_branches*`COMMIT_ID_WIDTH; all packed per REQ-008.
REQ-010 in_commit_flag, in_writes_external  in  n_branches each  per-branch flags.
REQ-011 in_accumulator  in  n_branches*full_width  packed signed accumulators.
REQ-012 out_valid  out  1; out_ready  in  1  merged output handshake.
REQ-013 result_out  data_width; dest_out  4; res_addr_out  8; commit_id_out  `COMMIT_ID_WIDTH; commit_flag_out, writes_external_out  1 each; accumulator_out  full_width; src_branch_out  BW.  All are registered outputs.

Function
REQ-014 The block has one output register slot; "slot_free" = ~out_valid | out_ready.
REQ-015 When enable=0, all in_ready are 0 and all registers hold.
REQ-016 When enable=1 and slot_free, exactly one eligible branch g is granted (in_ready[g]=1); with no eligible branch, in_ready=0.
REQ-017 Eligibility without REQ-027: in_valid[i]=1.
REQ-018 Grant is round-robin: first eligible index searching upward from (last_grant+1) mod n_branches, wrapping.
REQ-019 On grant, the next clock loads branch g's fields into the outputs, sets out_valid=1, src_branch_out=g and last_grant=g; latency 1 cycle.
REQ-020 Without a grant and with out_valid & out_ready, out_valid clears to 0.
REQ-021 Simultaneous output take and new grant in one cycle: out_valid stays 1, new data replaces old, no bubble.
REQ-022 With out_valid=1 and out_ready=0, outputs are stable and in_ready=0.
REQ-023 in_ready is combinational from in_valid, out_valid, out_ready, enable and internal state; it never depends on in_ready of the consumer of other channels.
REQ-024 Sustained throughput with out_ready=1 is one result per cycle.

Reset
REQ-025 On reset: out_valid=0, last_grant=n_branches-1 (so branch 0 has first priority), expected_id=0; all data outputs and src_branch_out=0.
REQ-026 Reset asserted mid-transfer discards the slot contents; no partial handshake survives reset.

Configuration
REQ-027 Macro BRANCH_MERGER_ORDERED_EN: when defined, branch i is eligible only if in_valid[i] and in_commit_id[i]==expected_id; ties resolved by REQ-018.
REQ-028 With BRANCH_MERGER_ORDERED_EN defined, expected_id increments by 1 (wrapping modulo 2^`COMMIT_ID_WIDTH) on each grant whose in_commit_flag=1; otherwise unchanged.
REQ-029 Without the macro, expected_id logic is absent and commit_id is passed through unchecked.

Verification
REQ-030 Reset then in_valid=0001, result=0x1234, out_ready=1 -> in_ready=0001 same cycle; next cycle out_valid=1, result_out=0x1234, src_branch_out=0.
REQ-031 All branches valid continuously, out_ready=1 -> grants 0,1,2,...,n-1,0 in consecutive cycles, one output per cycle.
REQ-032 out_valid=1, out_ready=0 for 5 cycles with branch 2 valid -> in_ready=0, outputs unchanged; out_ready=1 -> branch 2 granted that cycle, output updated next cycle without bubble.
REQ-033 enable=0 with branch 1 valid and slot empty -> in_ready=0, out_valid stays 0; enable=1 -> granted.
REQ-034 ORDERED_EN: branch 0 id=1, branch 1 id=0 flag=1 -> branch 1 first, then branch 0; expected_id wraps from 2^`COMMIT_ID_WIDTH-1 to 0.
REQ-035 Reset asserted while out_valid=1 -> next cycle out_valid=0, src_branch_out=0, first grant goes to branch 0.
